riscv_core_pipelined: RTL and testbench
=======================================

Name: riscv_core_pipelined

Overview:
- 5-stage in-order pipelined RV32I integer core: IF, ID, EX, MEM, WB.
- Harvard interface: instruction port to a combinational ROM; data port to a RAM with combinational read and synchronous write.
- Top-level CPU of the SoC, run in simulation with a program image (e.g. Fibonacci) preloaded in ROM.
- Hazards are handled internally by forwarding, load-use stall and branch flush. Programs need no software NOPs.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- ADDR_W, 10, width of iaddr/daddr; these are word (not byte) indices.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RSTn  input  1  asynchronous active-low reset.
- idata  input  32  instruction word at iaddr (combinational ROM).
- ddata_r  input  32  data word at daddr (combinational RAM read).
- iaddr  output  10  instruction word address = PC[11:2].
- daddr  output  10  data word address = MEM-stage ALU result[11:2].
- ddata_w  output  32  store data (rs2 value, forwarded).
- d_w  output  1  store enable; RAM writes on the next rising CLK.
- d_r  output  1  load enable.

Behaviour:
- Reset (RSTn=0, async):
  - PC=RESET_PC; all pipeline registers hold a bubble (valid=0, equivalent to addi x0,x0,0); register file x1..x31 cleared to 0.
  - Outputs: iaddr=0, d_w=0, d_r=0, daddr=0, ddata_w=0.
  - Reset asserted mid-run discards all in-flight instructions; no store is issued while RSTn=0.
- ISA subset:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW (word only; low 2 address bits ignored).
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Other opcodes execute as NOP (no register or memory write).
- Arithmetic: 32-bit two's complement, wrap-around on overflow, no traps. Shift amount is bits [4:0]. Immediates are sign-extended per RV32I formats.
- x0 reads as 0 always; writes to x0 are discarded.
- Register file: written on rising edge in WB. A read of a register being written the same cycle returns the new value (internal bypass).
- IF: iaddr=PC[11:2]. PC+4 each cycle unless stalled or redirected.
- Forwarding to EX operands and store data:
  - Priority: EX/MEM result > MEM/WB result > register file.
  - Only from producers with rd!=0.
- Load-use hazard: when the ID instruction reads rd of a load currently in EX:
  - PC and IF/ID hold for 1 cycle.
  - A bubble is inserted into EX.
  - The value then forwards from MEM/WB.
- Branches and jumps resolve in EX:
  - Taken branch/JAL/JALR: PC=target; the 2 younger instructions in IF/ID and ID/EX are flushed to bubbles.
  - Not-taken branch costs 0 cycles.
- Targets:
  - Branch/JAL target = PC+imm.
  - JALR target = (rs1+imm)&~1.
  - JAL/JALR write PC+4 to rd.
- MEM stage (driven combinationally from EX/MEM register):
  - daddr, ddata_w from EX/MEM.
  - d_w=1 only for a valid SW; d_r=1 only for a valid LW.
  - Bubbles drive d_w=d_r=0.
  - ddata_r is captured into MEM/WB at the rising edge.
- Latency: instruction fetched in cycle n writes its register at the rising edge ending cycle n+4. Steady-state throughput is 1 instruction/cycle.
- Program-counter wrap: PC is 32-bit; iaddr uses bits [11:2], so fetch wraps modulo 1024 words.

Test Plan:
- Reset: hold RSTn=0 two cycles, release at negedge -> iaddr=0,1,2,... on successive cycles; d_w=d_r=0 until first SW reaches MEM.
- Forwarding: addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sw x3,0(x0) with no NOPs -> one cycle with d_w=1, daddr=0, ddata_w=12; RAM word 0=12.
- Load-use: lw x4,0(x0) (RAM[0]=12); add x5,x4,x4; sw x5,4(x0) -> exactly one stall cycle (iaddr repeats once); RAM word 1=24.
- Branch flush: addi x1,x0,1; beq x1,x1,+12; addi x6,x0,99; addi x7,x0,99; sw x1,8(x0) -> RAM word 2=1; x6, x7 never written (a later sw of x6 stores 0).
- JAL/JALR: jal x1,+8 at PC 0x20 -> x1=0x24, next fetch iaddr=0x0A; jalr x0,0(x1) returns to iaddr=0x09.
- Fibonacci program, 1000 cycles -> RAM words 0..9 = 0,1,1,2,3,5,8,13,21,34. Asserting RSTn=0 mid-run restarts at iaddr=0 with no spurious d_w pulse.

Source files
------------

// File: rtl/riscv_core_pipelined.sv
// riscv_core_pipelined: 5-stage (IF/ID/EX/MEM/WB) in-order RV32I integer core.
// Harvard ports: combinational instruction ROM, data RAM with combinational
// read and synchronous write. Hazards are resolved in hardware by forwarding,
// a one-cycle load-use stall and a two-instruction flush on taken control flow.
module riscv_core_pipelined #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [31:0]       idata,
  input  logic [31:0]       ddata_r,
  output logic [ADDR_W-1:0] iaddr,
  output logic [ADDR_W-1:0] daddr,
  output logic [31:0]       ddata_w,
  output logic              d_w,
  output logic              d_r
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } idex_t;

  typedef struct packed {
    logic        we;
    logic        ld;
    logic        st;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] sd;
  } exmem_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
  } memwb_t;

  localparam ifid_t IFID_BUBBLE = '{vld: 1'b0, pc: 32'd0, instr: NOP};
  localparam idex_t IDEX_BUBBLE = '{vld: 1'b0, pc: 32'd0, instr: NOP,
                                    rs1_val: 32'd0, rs2_val: 32'd0};

  // Integer ALU shared by register and immediate forms; alt selects SUB/SRA.
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, sa < sb};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  if (alt) r = sa >>> b[4:0]; else r = a >> b[4:0];
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  // ---------------- ID: decode register usage and read the register file
  logic [6:0]  id_op;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic [31:0] id_rs1_val, id_rs2_val;

  assign id_op      = ifid_q.instr[6:0];
  assign id_rs1     = ifid_q.instr[19:15];
  assign id_rs2     = ifid_q.instr[24:20];
  assign id_use_rs1 = !(id_op == OP_LUI || id_op == OP_AUIPC || id_op == OP_JAL);
  assign id_use_rs2 = (id_op == OP_BR || id_op == OP_ST || id_op == OP_REG);

  // Register read; a write-back to the same register this cycle is bypassed.
  always_comb begin
    id_rs1_val = rf_q[id_rs1];
    id_rs2_val = rf_q[id_rs2];
    if (memwb_q.we && memwb_q.rd == id_rs1) id_rs1_val = memwb_q.res;
    if (memwb_q.we && memwb_q.rd == id_rs2) id_rs2_val = memwb_q.res;
    if (id_rs1 == 5'd0) id_rs1_val = 32'd0;
    if (id_rs2 == 5'd0) id_rs2_val = 32'd0;
  end

  // ---------------- EX: operand forwarding, ALU, branch resolution
  logic [31:0]        ex_instr;
  logic [6:0]         ex_op;
  logic [2:0]         ex_f3;
  logic [4:0]         ex_rd, ex_rs1, ex_rs2;
  logic [31:0]        ex_imm, ex_a, ex_b, ex_res, ex_target;
  logic signed [31:0] ex_a_s, ex_b_s;
  logic               ex_we, ex_ld, ex_st, ex_taken;

  assign ex_instr = idex_q.instr;
  assign ex_op    = ex_instr[6:0];
  assign ex_f3    = ex_instr[14:12];
  assign ex_rd    = ex_instr[11:7];
  assign ex_rs1   = ex_instr[19:15];
  assign ex_rs2   = ex_instr[24:20];
  assign ex_a_s   = ex_a;
  assign ex_b_s   = ex_b;

  // Immediate extraction, sign-extended per instruction format.
  always_comb begin
    case (ex_op)
      OP_LUI, OP_AUIPC: ex_imm = {ex_instr[31:12], 12'd0};
      OP_JAL:  ex_imm = {{12{ex_instr[31]}}, ex_instr[19:12], ex_instr[20],
                         ex_instr[30:21], 1'b0};
      OP_BR:   ex_imm = {{20{ex_instr[31]}}, ex_instr[7], ex_instr[30:25],
                         ex_instr[11:8], 1'b0};
      OP_ST:   ex_imm = {{20{ex_instr[31]}}, ex_instr[31:25], ex_instr[11:7]};
      default: ex_imm = {{20{ex_instr[31]}}, ex_instr[31:20]};
    endcase
  end

  // Forwarding: EX/MEM result beats MEM/WB result beats the value read in ID.
  always_comb begin
    ex_a = idex_q.rs1_val;
    ex_b = idex_q.rs2_val;
    if (ex_rs1 == 5'd0)                                ex_a = 32'd0;
    else if (exmem_q.we && exmem_q.rd == ex_rs1)       ex_a = exmem_q.res;
    else if (memwb_q.we && memwb_q.rd == ex_rs1)       ex_a = memwb_q.res;
    if (ex_rs2 == 5'd0)                                ex_b = 32'd0;
    else if (exmem_q.we && exmem_q.rd == ex_rs2)       ex_b = exmem_q.res;
    else if (memwb_q.we && memwb_q.rd == ex_rs2)       ex_b = memwb_q.res;
  end

  // Execute: result, write enable, memory intent and control-flow redirect.
  always_comb begin
    ex_res    = 32'd0;
    ex_we     = 1'b0;
    ex_ld     = 1'b0;
    ex_st     = 1'b0;
    ex_taken  = 1'b0;
    ex_target = idex_q.pc + ex_imm;
    if (idex_q.vld) begin
      case (ex_op)
        OP_LUI:   begin ex_res = ex_imm;               ex_we = 1'b1; end
        OP_AUIPC: begin ex_res = idex_q.pc + ex_imm;   ex_we = 1'b1; end
        OP_JAL:   begin ex_res = idex_q.pc + 32'd4;    ex_we = 1'b1; ex_taken = 1'b1; end
        OP_JALR: begin
          ex_res    = idex_q.pc + 32'd4;
          ex_we     = 1'b1;
          ex_taken  = 1'b1;
          ex_target = (ex_a + ex_imm) & ~32'd1;
        end
        OP_BR: begin
          case (ex_f3)
            3'b000:  ex_taken = (ex_a == ex_b);
            3'b001:  ex_taken = (ex_a != ex_b);
            3'b100:  ex_taken = (ex_a_s < ex_b_s);
            3'b101:  ex_taken = (ex_a_s >= ex_b_s);
            3'b110:  ex_taken = (ex_a < ex_b);
            3'b111:  ex_taken = (ex_a >= ex_b);
            default: ex_taken = 1'b0;
          endcase
        end
        OP_LD: if (ex_f3 == 3'b010) begin
          ex_res = ex_a + ex_imm;
          ex_we  = 1'b1;
          ex_ld  = 1'b1;
        end
        OP_ST: if (ex_f3 == 3'b010) begin
          ex_res = ex_a + ex_imm;
          ex_st  = 1'b1;
        end
        OP_IMM: begin
          ex_res = alu(ex_f3, ex_instr[30] && ex_f3 == 3'b101, ex_a, ex_imm);
          ex_we  = 1'b1;
        end
        OP_REG: begin
          ex_res = alu(ex_f3, ex_instr[30], ex_a, ex_b);
          ex_we  = 1'b1;
        end
        default: ;
      endcase
    end
    if (ex_rd == 5'd0) ex_we = 1'b0;
  end

  // ---------------- Hazard control and pipeline register next-state
  logic load_use;

  assign load_use = ex_ld && ifid_q.vld &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  // Fetch/decode advance; a taken redirect flushes, a load-use hazard holds IF/ID.
  always_comb begin
    pc_d   = pc_q + 32'd4;
    ifid_d = '{vld: 1'b1, pc: pc_q, instr: idata};
    idex_d = '{vld: ifid_q.vld, pc: ifid_q.pc, instr: ifid_q.instr,
               rs1_val: id_rs1_val, rs2_val: id_rs2_val};
    if (ex_taken) begin
      pc_d   = ex_target;
      ifid_d = IFID_BUBBLE;
      idex_d = IDEX_BUBBLE;
    end else if (load_use) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = IDEX_BUBBLE;
    end
  end

  // ---------------- MEM: data port driven from EX/MEM, load data captured to MEM/WB
  assign daddr   = exmem_q.res[ADDR_W+1:2];
  assign ddata_w = exmem_q.sd;
  assign d_w     = exmem_q.st;
  assign d_r     = exmem_q.ld;
  assign iaddr   = pc_q[ADDR_W+1:2];

  // EX/MEM and MEM/WB next-state.
  always_comb begin
    exmem_d = '{we: ex_we, ld: ex_ld, st: ex_st, rd: ex_rd, res: ex_res, sd: ex_b};
    memwb_d = '{we: exmem_q.we, rd: exmem_q.rd,
                res: exmem_q.ld ? ddata_r : exmem_q.res};
  end

  // ---------------- WB: register file write (x0 never enabled)
  always_comb begin
    rf_d = rf_q;
    if (memwb_q.we) rf_d[memwb_q.rd] = memwb_q.res;
  end

  // State registers; reset empties the pipeline and clears the register file.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pc_q    <= RESET_PC;
      ifid_q  <= IFID_BUBBLE;
      idex_q  <= IDEX_BUBBLE;
      exmem_q <= '0;
      memwb_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_pipelined.sv
// Testbench for riscv_core_pipelined: ROM/RAM models, store scoreboard,
// fetch-address traces and a Fibonacci run with a mid-run reset.
module tb_riscv_core_pipelined;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] idata, ddata_r, ddata_w;
  logic [9:0]  iaddr, daddr;
  logic        d_w, d_r;

  logic [31:0] rom [1024];
  logic [31:0] ram [1024];
  logic        ram_clr;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } st_t;

  st_t exp_q [$];
  st_t mon_e;
  int  n_tests, n_fail, n_stores;
  int  tr [$];
  int  fib [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};

  always #5 CLK = ~CLK;

  riscv_core_pipelined dut (
    .CLK(CLK), .RSTn(RSTn), .idata(idata), .ddata_r(ddata_r),
    .iaddr(iaddr), .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r)
  );

  assign idata   = rom[iaddr];
  assign ddata_r = ram[daddr];

  always @(posedge CLK) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'd0;
    end else if (d_w) begin
      ram[daddr] <= ddata_w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Store scoreboard: every d_w pulse must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (d_w) begin
      if (!RSTn) chk("dw_during_reset", 32'(d_w), 32'd0);
      else if (exp_q.size() == 0) chk("store_expected", 32'(exp_q.size()), 32'd1);
      else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("st%0d_addr", n_stores), 32'(daddr), 32'(mon_e.a));
        chk($sformatf("st%0d_data", n_stores), ddata_w, mon_e.d);
        n_stores++;
      end
    end
  end

  // Instruction encoders.
  function automatic logic [31:0] f_i(input int imm, input int rs1, input int f3,
                                      input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return f_i(imm, rs1, 0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] f_r(input int f7, input int f3, input int rd,
                                      input int rs1, input int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] jal(input int rd, input int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0000_0013;
  endtask

  task automatic expect_st(input int a, input logic [31:0] d);
    st_t e;
    e.a = a[9:0];
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_iaddr"},   32'(iaddr), 32'd0);
    chk({tag, "_d_w"},     32'(d_w),   32'd0);
    chk({tag, "_d_r"},     32'(d_r),   32'd0);
    chk({tag, "_daddr"},   32'(daddr), 32'd0);
    chk({tag, "_ddata_w"}, ddata_w,    32'd0);
  endtask

  // Assert reset, check outputs asynchronously, hold two cycles, return at a negedge.
  task automatic enter_reset(input string tag);
    RSTn    = 1'b0;
    ram_clr = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge CLK);
    n_stores = 0;
    ram_clr  = 1'b0;
  endtask

  task automatic trace(input string tag);
    foreach (tr[c]) begin
      chk($sformatf("%s_iaddr_c%0d", tag, c), 32'(iaddr), 32'(tr[c]));
      @(negedge CLK);
    end
  endtask

  task automatic wait_stores(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && n_stores < n; i++) @(negedge CLK);
    #1;
    chk({tag, "_store_count"}, 32'(n_stores), 32'(n));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    RSTn = 1'b1; ram_clr = 1'b0;
    n_tests = 0; n_fail = 0; n_stores = 0;
    clear_rom();
    #2;

    // Forwarding, load-use stall, branch flush, signed/unsigned ALU ops.
    enter_reset("a_rst");
    clear_rom();
    rom[0]  = addi(1, 0, 5);
    rom[1]  = addi(2, 0, 7);
    rom[2]  = f_r(7'h00, 0, 3, 1, 2);     // add x3,x1,x2
    rom[3]  = sw(3, 0, 0);
    rom[4]  = f_i(0, 0, 2, 4, 7'h03);     // lw x4,0(x0)
    rom[5]  = f_r(7'h00, 0, 5, 4, 4);     // add x5,x4,x4
    rom[6]  = sw(5, 0, 4);
    rom[7]  = addi(1, 0, 1);
    rom[8]  = br(0, 1, 1, 12);            // beq x1,x1,+12
    rom[9]  = addi(6, 0, 99);
    rom[10] = addi(7, 0, 99);
    rom[11] = sw(1, 0, 8);
    rom[12] = sw(6, 0, 12);
    rom[13] = sw(7, 0, 16);
    rom[14] = addi(8, 0, -8);
    rom[15] = f_i(12'h401, 8, 5, 9, 7'h13);  // srai x9,x8,1
    rom[16] = f_r(7'h00, 3, 10, 0, 8);    // sltu x10,x0,x8
    rom[17] = f_r(7'h00, 2, 11, 8, 0);    // slt x11,x8,x0
    rom[18] = f_r(7'h20, 0, 12, 0, 8);    // sub x12,x0,x8
    rom[19] = {20'h12345, 5'd13, 7'h37};  // lui x13,0x12345
    rom[20] = sw(9, 0, 20);
    rom[21] = sw(10, 0, 24);
    rom[22] = sw(11, 0, 28);
    rom[23] = sw(12, 0, 32);
    rom[24] = sw(13, 0, 36);
    rom[25] = jal(0, 0);
    expect_st(0, 32'd12);
    expect_st(1, 32'd24);
    expect_st(2, 32'd1);
    expect_st(3, 32'd0);
    expect_st(4, 32'd0);
    expect_st(5, 32'hFFFF_FFFC);
    expect_st(6, 32'd1);
    expect_st(7, 32'd1);
    expect_st(8, 32'd8);
    expect_st(9, 32'h1234_5000);
    RSTn = 1'b1;
    tr = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 8};
    trace("a");
    wait_stores(10, 300, "a");
    chk("a_ram0", ram[0], 32'd12);
    chk("a_ram1", ram[1], 32'd24);
    chk("a_ram2", ram[2], 32'd1);

    // JAL / JALR link value and redirect.
    enter_reset("b_rst");
    clear_rom();
    rom[8]  = jal(1, 8);                  // 0x20: jal x1,+8
    rom[9]  = jal(0, 16);                 // 0x24: jal x0,+16
    rom[10] = sw(1, 0, 0);                // 0x28
    rom[11] = f_i(0, 1, 0, 0, 7'h67);     // 0x2C: jalr x0,0(x1)
    rom[12] = addi(9, 0, 55);             // 0x30: skipped
    rom[13] = sw(9, 0, 4);                // 0x34
    rom[14] = jal(0, 0);
    expect_st(0, 32'h24);
    expect_st(1, 32'd0);
    RSTn = 1'b1;
    tr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 11, 12, 13, 9, 10, 11, 13};
    trace("b");
    wait_stores(2, 100, "b");

    // Fibonacci with a mid-run reset.
    enter_reset("c_rst");
    clear_rom();
    rom[0]  = addi(1, 0, 0);
    rom[1]  = addi(2, 0, 1);
    rom[2]  = addi(3, 0, 0);
    rom[3]  = addi(4, 0, 40);
    rom[4]  = sw(1, 3, 0);
    rom[5]  = f_r(7'h00, 0, 5, 1, 2);
    rom[6]  = addi(1, 2, 0);
    rom[7]  = addi(2, 5, 0);
    rom[8]  = addi(3, 3, 4);
    rom[9]  = br(1, 3, 4, -20);           // bne x3,x4,loop
    rom[10] = jal(0, 0);
    for (int i = 0; i < 10; i++) expect_st(i, fib[i]);
    RSTn = 1'b1;
    tr = '{0, 1, 2, 3};
    trace("c");
    for (int i = 0; i < 500 && n_stores < 4; i++) @(negedge CLK);
    chk("c_stores_before_reset", 32'(n_stores >= 4), 32'd1);
    @(posedge CLK);
    #2;
    enter_reset("c_midrst");
    for (int i = 0; i < 10; i++) expect_st(i, fib[i]);
    RSTn = 1'b1;
    tr = '{0, 1, 2};
    trace("c_restart");
    wait_stores(10, 1000, "c");
    for (int i = 0; i < 10; i++) chk($sformatf("c_ram%0d", i), ram[i], fib[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
